// File: rtl/drm_metering_arbiter.sv
// -----------------------------------------------------------------------------
// drm_metering_arbiter
//
// Purpose:
//   Shares the single metering_event input of the DRM activator between
//   NUM_REQ user-IP requesters. Each requester's event pulses are buffered in
//   a saturating pending counter. They are then emitted one at a time as
//   single-cycle pulses. Requesters are served round-robin, new grants are
//   held off while the DRM is not activated, and at least GAP_CYCLES low
//   cycles are forced between pulses.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   req_event       per-requester 1-cycle event pulses (any combination)
//   activated       DRM activation status; 1 permits new grants
//   clear_overflow  1-cycle pulse clearing all overflow flags
//   metering_event  registered single-cycle pulse to the DRM activator
//   event_src       requester index owning the current/last pulse
//   pending_any     registered OR of all pending counters
//   pending_cnt     flat pending counters, requester i at [i*CNT_W +: CNT_W]
//   overflow        sticky per-requester "event lost to saturation" flags
//   emitted_total   free-running count of emitted pulses (wraps)
//
// FSM states:
//   state  | meaning
//   IDLE   | looking for a pending requester; grants when activated
//   EMIT   | metering_event is high for this single cycle
//   GAP    | forced low cycles before the next grant may be made
// -----------------------------------------------------------------------------
module drm_metering_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_event,
  input  logic                       activated,
  input  logic                       clear_overflow,
  output logic                       metering_event,
  output logic [$clog2(NUM_REQ)-1:0] event_src,
  output logic                       pending_any,
  output logic [NUM_REQ*CNT_W-1:0]   pending_cnt,
  output logic [NUM_REQ-1:0]         overflow,
  output logic [31:0]                emitted_total
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int GAP_W = 8;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e              state_q;
  logic [SRC_W-1:0]    rr_ptr_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                meter_q;
  logic [SRC_W-1:0]    src_q;
  logic                pend_any_q;
  logic                pend_any_d;
  logic [31:0]         total_q;
  logic [NUM_REQ-1:0]  ovf_q;
  logic [NUM_REQ-1:0]  ovf_d;
  logic [NUM_REQ-1:0]  ovf_set;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];
  logic [CNT_W-1:0]    cnt_d [NUM_REQ];

  logic                grant_vld;
  logic [SRC_W-1:0]    grant_idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (state_q == S_IDLE && activated) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_vld && cnt_q[idx] != '0) begin
          grant_vld = 1'b1;
          grant_idx = SRC_W'(idx);
        end
      end
    end
  end

  // Pending counters: a simultaneous event and grant cancel out, so the
  // event is neither lost nor double counted.
  always_comb begin
    logic inc;
    logic dec;
    inc        = 1'b0;
    dec        = 1'b0;
    ovf_set    = '0;
    pend_any_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc      = req_event[i];
      dec      = grant_vld && (grant_idx == SRC_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!inc && dec) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      pend_any_d = pend_any_d | (cnt_d[i] != '0);
    end
    // A new overflow in the same cycle as a clear must not be lost.
    ovf_d = (clear_overflow ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q      <= '0;
      pend_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      pend_any_q <= pend_any_d;
    end
  end

  // Emission FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= SRC_W'(NUM_REQ - 1);
      gap_cnt_q <= '0;
      meter_q   <= 1'b0;
      src_q     <= '0;
      total_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            rr_ptr_q <= grant_idx;
            src_q    <= grant_idx;
            meter_q  <= 1'b1;
            state_q  <= S_EMIT;
          end
        end
        S_EMIT: begin
          meter_q <= 1'b0;
          total_q <= total_q + 32'd1;
          if (GAP_CYCLES > 0) begin
            gap_cnt_q <= GAP_W'(GAP_LOAD);
            state_q   <= S_GAP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          meter_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign pending_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign metering_event = meter_q;
  assign event_src      = src_q;
  assign pending_any    = pend_any_q;
  assign overflow       = ovf_q;
  assign emitted_total  = total_q;

endmodule
